// File: rtl/alu_sequencer.sv
// Step-driven A/B ALU sequencer: operands enter one per STEP, a single EXEC cycle registers result and flags.
// Optional build macro ALU_SEQ_SATURATE_EN makes ADD/SUB saturate on signed overflow.
module alu_sequencer #(
  parameter int N   = 8,
  parameter int SHW = $clog2(N)
) (
  input  logic         CLK50M,
  input  logic         RST,
  input  logic [N-1:0] INPUT,
  input  logic [2:0]   OPSEL,
  input  logic         STEP,
  input  logic         CHAIN,
  output logic [N-1:0] A_q,
  output logic [N-1:0] B_q,
  output logic [N-1:0] C_q,
  output logic         V,
  output logic         C,
  output logic         Neg,
  output logic         Z,
  output logic [1:0]   STATE,
  output logic         DONE
);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    EXEC   = 2'b10,
    SHOW   = 2'b11
  } state_t;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_SHL   = 3'b101;
  localparam logic [2:0] OP_SHR   = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [2:0]     op_r;
  logic           load_a_s;
  logic           a_from_c_s;
  logic           load_b_s;
  logic           exec_s;

  logic [SHW-1:0] amt_s;
  logic [N:0]     add_s;
  logic [N:0]     sub_s;
  logic [N:0]     shl_s;
  logic [N:0]     shr_s;
  logic [N-1:0]   raw_s;
  logic [N-1:0]   res_s;
  logic           v_s;
  logic           c_s;

  assign STATE = state_r;

  // Next-state and register-load enables; EXEC is a single unconditional cycle that ignores STEP.
  always_comb begin
    state_nxt_s = state_r;
    load_a_s    = 1'b0;
    a_from_c_s  = 1'b0;
    load_b_s    = 1'b0;
    exec_s      = 1'b0;
    case (state_r)
      LOAD_A: begin
        if (STEP) begin
          load_a_s    = 1'b1;
          state_nxt_s = LOAD_B;
        end else begin
          state_nxt_s = LOAD_A;
        end
      end
      LOAD_B: begin
        if (STEP) begin
          load_b_s    = 1'b1;
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = LOAD_B;
        end
      end
      EXEC: begin
        exec_s      = 1'b1;
        state_nxt_s = SHOW;
      end
      SHOW: begin
        if (STEP) begin
          load_a_s    = 1'b1;
          a_from_c_s  = CHAIN;
          state_nxt_s = LOAD_B;
        end else begin
          state_nxt_s = SHOW;
        end
      end
      default: begin
        state_nxt_s = LOAD_A;
      end
    endcase
  end

  // ALU: one extra bit on each path carries the carry-out or the last bit shifted out.
  always_comb begin
    amt_s = B_q[SHW-1:0];
    add_s = {1'b0, A_q} + {1'b0, B_q};
    sub_s = {1'b0, A_q} + {1'b0, ~B_q} + {{N{1'b0}}, 1'b1};
    shl_s = {1'b0, A_q} << amt_s;
    shr_s = {A_q, 1'b0} >> amt_s;
    raw_s = {N{1'b0}};
    v_s   = 1'b0;
    c_s   = 1'b0;
    case (op_r)
      OP_ADD: begin
        raw_s = add_s[N-1:0];
        c_s   = add_s[N];
        v_s   = (A_q[N-1] == B_q[N-1]) && (add_s[N-1] != A_q[N-1]);
      end
      OP_SUB: begin
        raw_s = sub_s[N-1:0];
        c_s   = sub_s[N];
        v_s   = (A_q[N-1] != B_q[N-1]) && (sub_s[N-1] != A_q[N-1]);
      end
      OP_AND: begin
        raw_s = A_q & B_q;
      end
      OP_OR: begin
        raw_s = A_q | B_q;
      end
      OP_XOR: begin
        raw_s = A_q ^ B_q;
      end
      OP_SHL: begin
        raw_s = shl_s[N-1:0];
        c_s   = shl_s[N];
      end
      OP_SHR: begin
        raw_s = shr_s[N:1];
        c_s   = shr_s[0];
      end
      OP_PASSB: begin
        raw_s = B_q;
      end
      default: begin
        raw_s = {N{1'b0}};
      end
    endcase
  end

  // Final result: optional clamp toward the sign of A when ADD/SUB overflows.
  always_comb begin
`ifdef ALU_SEQ_SATURATE_EN
    if (((op_r == OP_ADD) || (op_r == OP_SUB)) && v_s) begin
      if (A_q[N-1]) begin
        res_s = {1'b1, {(N-1){1'b0}}};
      end else begin
        res_s = {1'b0, {(N-1){1'b1}}};
      end
    end else begin
      res_s = raw_s;
    end
`else
    res_s = raw_s;
`endif
  end

  // State, operand, result and flag registers; RST wins over any STEP in the same cycle.
  always_ff @(posedge CLK50M) begin
    if (RST) begin
      state_r <= LOAD_A;
      op_r    <= 3'b000;
      A_q     <= {N{1'b0}};
      B_q     <= {N{1'b0}};
      C_q     <= {N{1'b0}};
      V       <= 1'b0;
      C       <= 1'b0;
      Neg     <= 1'b0;
      Z       <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      DONE    <= exec_s;
      if (load_a_s) begin
        A_q  <= a_from_c_s ? C_q : INPUT;
        op_r <= OPSEL;
      end
      if (load_b_s) begin
        B_q <= INPUT;
      end
      if (exec_s) begin
        C_q <= res_s;
        V   <= v_s;
        C   <= c_s;
        Neg <= res_s[N-1];
        Z   <= (res_s == {N{1'b0}});
      end
    end
  end

endmodule
